// File: rtl/lsu_pipe_if.sv
// Core request, memory beat and completion signals of the load/store unit.
// master = core + memory environment, slave = lsu_pipe.
interface lsu_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_web;
  logic [DATA_W-1:0] mem_bweb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_req, mem_web, mem_bweb, mem_addr, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_req, mem_web, mem_bweb, mem_addr, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_pipe.sv
// Load/store unit: one request at a time, misaligned accesses split into two
// memory beats, load data realigned and sign/zero extended.
module lsu_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  lsu_pipe_if.slave bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned W2    = 2 * DATA_W;
  localparam int unsigned B2    = 2 * BYTES;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              split_q, split_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Classification of the incoming request, evaluated at accept time
  logic [3:0] in_nbytes;
  logic [4:0] in_span;
  logic       in_illegal, in_mis, in_err;

  assign in_nbytes  = 4'd1 << bus.req_size;
  assign in_span    = 5'(bus.req_addr[OFF_W-1:0]) + 5'(in_nbytes);
  assign in_illegal = 5'(in_nbytes) > 5'(BYTES);
  assign in_mis     = in_span > 5'(BYTES);
  assign in_err     = in_illegal || (in_mis && !SPLIT_EN);

  logic [OFF_W-1:0]  off;
  logic [3:0]        nbytes;
  logic [DATA_W-1:0] size_mask;
  logic [ADDR_W-1:0] base_addr;
  logic [B2-1:0]     be_w;
  logic [W2-1:0]     wd_w;

  assign off       = addr_q[OFF_W-1:0];
  assign nbytes    = 4'd1 << size_q;
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  // Enables/data span two beats; the upper half is what spills into beat1
  assign be_w      = ((B2'(1) << nbytes) - B2'(1)) << off;
  assign wd_w      = W2'(wdata_q & size_mask) << {off, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    size_mask = DATA_W'(8'hFF);
      2'd1:    size_mask = DATA_W'(16'hFFFF);
      2'd2:    size_mask = DATA_W'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  end

  logic [DATA_W-1:0] ld_lo, ld_hi, ld_raw, ld_ext;
  logic [W2-1:0]     ld_w;
  logic              ld_sign;

  always_comb begin
    ld_lo  = (state_q == WAIT1) ? rd0_q : bus.mem_rdata;
    ld_hi  = (state_q == WAIT1) ? bus.mem_rdata : '0;
    ld_w   = {ld_hi, ld_lo} >> {off, 3'b000};
    ld_raw = ld_w[DATA_W-1:0] & size_mask;
    case (size_q)
      2'd0:    ld_sign = ld_raw[7];
      2'd1:    ld_sign = ld_raw[15];
      2'd2:    ld_sign = ld_raw[31];
      default: ld_sign = ld_raw[DATA_W-1];
    endcase
    ld_ext = (ld_sign && !uns_q) ? (ld_raw | ~size_mask) : ld_raw;
  end

  logic              mem_req, mem_web;
  logic [BYTES-1:0]  be_sel;
  logic [DATA_W-1:0] mem_bweb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_req   = 1'b0;
    mem_web   = 1'b1;
    be_sel    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == REQ0) begin
      mem_req  = 1'b1;
      mem_addr = base_addr;
      if (we_q) begin
        mem_web   = 1'b0;
        be_sel    = be_w[BYTES-1:0];
        mem_wdata = wd_w[DATA_W-1:0];
      end
    end else if (state_q == REQ1) begin
      mem_req  = 1'b1;
      mem_addr = base_addr + ADDR_W'(BYTES);
      if (we_q) begin
        mem_web   = 1'b0;
        be_sel    = be_w[B2-1:BYTES];
        mem_wdata = wd_w[W2-1:DATA_W];
      end
    end
  end

  for (genvar b = 0; b < BYTES; b++) begin : g_bweb
    assign mem_bweb[8*b +: 8] = {8{~be_sel[b]}};
  end

  logic req_ready, resp_valid;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    uns_d      = uns_q;
    split_d    = split_q;
    err_d      = err_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd0_d      = rd0_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          size_d  = bus.req_size;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          split_d = in_mis;
          err_d   = in_err;
          rdata_d = '0;
          state_d = in_err ? RESP : REQ0;
        end
      end
      REQ0: if (bus.mem_gnt) state_d = !we_q ? WAIT0 : (split_q ? REQ1 : RESP);
      WAIT0: begin
        if (bus.mem_rvalid) begin
          if (split_q) begin
            rd0_d   = bus.mem_rdata;
            state_d = REQ1;
          end else begin
            rdata_d = ld_ext;
            state_d = RESP;
          end
        end
      end
      REQ1: if (bus.mem_gnt) state_d = we_q ? RESP : WAIT1;
      WAIT1: begin
        if (bus.mem_rvalid) begin
          rdata_d = ld_ext;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      split_q <= split_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mem_req    = mem_req;
  assign bus.mem_web    = mem_web;
  assign bus.mem_bweb   = mem_bweb;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign bus.resp_err   = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: aligned/misaligned stores and loads, extension,
// error responses, grant stalls and reset in mid-split.
module tb_lsu_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  lsu_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus_ns ();

  lsu_pipe #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  lsu_pipe #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst), .bus(bus_ns)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;   bus_ns.req_valid = 1'b0;
    bus.req_we = 1'b0;      bus_ns.req_we = 1'b0;
    bus.req_size = 2'd0;    bus_ns.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus_ns.req_unsigned = 1'b0;
    bus.req_addr = '0;      bus_ns.req_addr = '0;
    bus.req_wdata = '0;     bus_ns.req_wdata = '0;
    bus.mem_gnt = 1'b0;     bus_ns.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;  bus_ns.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;     bus_ns.mem_rdata = '0;
    bus.resp_ready = 1'b0;  bus_ns.resp_ready = 1'b0;
  endtask

  task automatic accept(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    check("req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("resp_drop", bus.resp_valid, 0);
    check("ready_back", bus.req_ready, 1);
  endtask

  // Loads: size, unsigned, address, memory word, expected result
  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[6];

  initial begin
    ld_tab[0] = '{2'd1, 1'b0, 32'h0000_0000, 32'h0000_8001, 32'hFFFF_8001};
    ld_tab[1] = '{2'd1, 1'b1, 32'h0000_0000, 32'h0000_8001, 32'h0000_8001};
    ld_tab[2] = '{2'd0, 1'b0, 32'h0000_0101, 32'h0000_F100, 32'hFFFF_FFF1};
    ld_tab[3] = '{2'd0, 1'b1, 32'h0000_0101, 32'h0000_F100, 32'h0000_00F1};
    ld_tab[4] = '{2'd1, 1'b0, 32'h0000_0202, 32'h7FFF_0000, 32'h0000_7FFF};
    ld_tab[5] = '{2'd2, 1'b0, 32'h0000_0004, 32'h8000_0001, 32'h8000_0001};

    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_web", bus.mem_web, 1);
    check("rst_bweb", bus.mem_bweb, 32'hFFFF_FFFF);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    rst = 1'b0;
    tick();
    check("rel_req_ready", bus.req_ready, 1);

    // Aligned SW, immediate grant
    bus.mem_gnt = 1'b1;
    accept(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
    check("sw_req", bus.mem_req, 1);
    check("sw_web", bus.mem_web, 0);
    check("sw_bweb", bus.mem_bweb, 32'h0000_0000);
    check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("sw_addr", bus.mem_addr, 32'h100);
    check("sw_ready_busy", bus.req_ready, 0);
    check("sw_early_resp", bus.resp_valid, 0);
    tick();
    bus.mem_gnt = 1'b0;
    check("sw_lat2", bus.resp_valid, 1);
    check("sw_rdata0", bus.resp_rdata, 0);
    check("sw_err0", bus.resp_err, 0);
    check("sw_req_off", bus.mem_req, 0);
    tick();
    check("sw_hold", bus.resp_valid, 1);
    release_resp();

    // SB into top lane
    bus.mem_gnt = 1'b1;
    accept(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5);
    check("sb_addr", bus.mem_addr, 32'h100);
    check("sb_bweb", bus.mem_bweb, 32'h00FF_FFFF);
    check("sb_wdata", bus.mem_wdata, 32'hA500_0000);
    tick();
    bus.mem_gnt = 1'b0;
    check("sb_resp", bus.resp_valid, 1);
    release_resp();

    // Misaligned SW split across two beats
    bus.mem_gnt = 1'b1;
    accept(1'b1, 2'd2, 1'b0, 32'h103, 32'hAABB_CCDD);
    check("ssw_b0_addr", bus.mem_addr, 32'h100);
    check("ssw_b0_bweb", bus.mem_bweb, 32'h00FF_FFFF);
    check("ssw_b0_wdata", bus.mem_wdata, 32'hDD00_0000);
    tick();
    check("ssw_b1_req", bus.mem_req, 1);
    check("ssw_b1_addr", bus.mem_addr, 32'h104);
    check("ssw_b1_bweb", bus.mem_bweb, 32'hFF00_0000);
    check("ssw_b1_wdata", bus.mem_wdata, 32'h00AA_BBCC);
    tick();
    bus.mem_gnt = 1'b0;
    check("ssw_resp", bus.resp_valid, 1);
    release_resp();

    // Misaligned LW with a grant stall on beat0
    accept(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    check("slw_b0_addr", bus.mem_addr, 32'h100);
    check("slw_web", bus.mem_web, 1);
    check("slw_bweb", bus.mem_bweb, 32'hFFFF_FFFF);
    tick();
    check("slw_stall_req", bus.mem_req, 1);
    check("slw_stall_addr", bus.mem_addr, 32'h100);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("slw_wait0", bus.mem_req, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_ABCD;
    tick();
    bus.mem_rvalid = 1'b0;
    check("slw_b1_req", bus.mem_req, 1);
    check("slw_b1_addr", bus.mem_addr, 32'h104);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick();
    check("slw_wait1", bus.resp_valid, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hEEFF_3344;
    tick();
    bus.mem_rvalid = 1'b0;
    check("slw_resp", bus.resp_valid, 1);
    check("slw_rdata", bus.resp_rdata, 32'h3344_1122);
    check("slw_err", bus.resp_err, 0);
    release_resp();

    // Single-beat loads: size/extension table, 3-cycle latency
    foreach (ld_tab[i]) begin
      bus.mem_gnt = 1'b1;
      accept(1'b0, ld_tab[i].size, ld_tab[i].uns, ld_tab[i].addr, 32'h0);
      check($sformatf("ld%0d_addr", i), bus.mem_addr, ld_tab[i].addr & 32'hFFFF_FFFC);
      tick();
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = ld_tab[i].rdata;
      tick();
      bus.mem_rvalid = 1'b0;
      check($sformatf("ld%0d_lat3", i), bus.resp_valid, 1);
      check($sformatf("ld%0d_rdata", i), bus.resp_rdata, ld_tab[i].exp);
      release_resp();
    end

    // Stray rvalid while idle
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    tick();
    tick();
    bus.mem_rvalid = 1'b0;
    check("stray_resp", bus.resp_valid, 0);
    check("stray_ready", bus.req_ready, 1);

    // Dword on a 32-bit datapath
    accept(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    check("dw_resp", bus.resp_valid, 1);
    check("dw_err", bus.resp_err, 1);
    check("dw_no_req", bus.mem_req, 0);
    release_resp();

    // Splitting disabled
    bus_ns.req_valid = 1'b1;
    bus_ns.req_we    = 1'b0;
    bus_ns.req_size  = 2'd2;
    bus_ns.req_addr  = 32'h1;
    tick();
    bus_ns.req_valid = 1'b0;
    check("ns_no_req", bus_ns.mem_req, 0);
    check("ns_resp", bus_ns.resp_valid, 1);
    check("ns_err", bus_ns.resp_err, 1);
    bus_ns.resp_ready = 1'b1;
    tick();
    bus_ns.resp_ready = 1'b0;
    check("ns_drop", bus_ns.resp_valid, 0);

    // Reset asserted in WAIT1, then a late rvalid
    bus.mem_gnt = 1'b1;
    accept(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_ABCD;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("wait1_busy", bus.req_ready, 0);
    rst = 1'b1;
    #1;
    check("async_ready", bus.req_ready, 1);
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hEEFF_3344;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    check("post_rst_resp", bus.resp_valid, 0);
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_req", bus.mem_req, 0);
    check("post_rst_web", bus.mem_web, 1);
    check("post_rst_bweb", bus.mem_bweb, 32'hFFFF_FFFF);
    check("post_rst_addr", bus.mem_addr, 0);
    check("post_rst_wdata", bus.mem_wdata, 0);
    check("post_rst_rdata", bus.resp_rdata, 0);
    check("post_rst_err", bus.resp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
